watch_cmd_scheduler: RTL
========================

# watch_cmd_scheduler

- Sits in front of `stopwatch_cu` and `time_cu`.
- Merges debounced button pulses and UART receive bytes into single-cycle command pulses for those two controllers.
- Routes each command by the active mode (stopwatch or watch).
- Enforces a lockout gap between issued commands so no controller sees back-to-back or coincident commands.

## Interface
Parameters:
- `LOCKOUT_CYCLES`, 4: idle cycles forced after each issued pulse; range 0..15.

Ports:
- `clk`  in  1  system clock.
- `reset`  in  1  synchronous, active-high reset.
- `i_mode`  in  1  selects the command target: 0 = stopwatch, 1 = watch. Level input, sampled every cycle.
- `i_setting`  in  1  watch-setting switch. Level input.
- `i_btn_left`, `i_btn_right`, `i_btn_up`, `i_btn_down`  in  1 each  debounced one-cycle button pulses.
- `i_rx_data`  in  8  UART byte; valid when `i_rx_done` = 1.
- `i_rx_done`  in  1  one-cycle byte strobe.
- `o_sw_runstop`, `o_sw_clear`, `o_sw_start`, `o_sw_stop`  out  1 each  stopwatch command pulses.
- `o_tm_left`, `o_tm_right`, `o_tm_up`, `o_tm_down`  out  1 each  watch-setting command pulses.
- `o_busy`  out  1  high whenever the state is not IDLE.
- `o_cmd_drop`  out  1  one-cycle pulse: a UART command was discarded.
- `o_cmd_err`  out  1  one-cycle pulse: an unrecognised UART byte was received.

## Operation
UART decode (case-sensitive ASCII):
- Stopwatch class: `R` 0x52 → start, `S` 0x53 → stop, `C` 0x43 → clear.
- Watch class: `l` 0x6C → left, `r` 0x72 → right, `u` 0x75 → up, `d` 0x64 → down.
- Any other byte with `i_rx_done` → `o_cmd_err` pulses next cycle; nothing is stored.

Pending slot (1-deep):
- Holds a valid bit and a 3-bit code.
- A recognised byte is written into the slot at the end of its `i_rx_done` cycle.
- If the slot is still valid and not being consumed that cycle, the new byte is dropped and `o_cmd_drop` pulses.
- If the slot is consumed in the same cycle that a new byte arrives, the new byte is stored.

Button mapping:
- Mode 0: up → runstop, down → clear; left and right are ignored.
- Mode 1: each button maps to its watch pulse.
- Simultaneous buttons resolve by priority up > down > left > right; the others are discarded.

Mode and setting gating, evaluated at acceptance:
- A command is applicable only if its class matches `i_mode`.
- Watch commands also require `i_setting` = 1.
- An inapplicable button is discarded silently; it causes no issue and no lockout.
- An inapplicable pending UART command is consumed, `o_cmd_drop` pulses, and the state stays IDLE.

State machine (IDLE, ISSUE, LOCK):
- IDLE: an applicable button wins over an applicable pending command. On acceptance the command code is latched and the state moves to ISSUE. A pending command that loses arbitration stays pending.
- ISSUE: exactly one output pulse, decoded from the latched code. Next state is LOCK, or IDLE if `LOCKOUT_CYCLES` = 0. The lockout counter loads `LOCKOUT_CYCLES`-1.
- LOCK: the counter decrements each cycle; the state moves to IDLE when the counter reaches 0.
- Button pulses during ISSUE or LOCK are discarded.
- UART bytes during ISSUE or LOCK still load the pending slot, subject to the drop rule.

## Timing
- Reset (synchronous) state:
  - all outputs 0;
  - state IDLE;
  - pending slot invalid;
  - counter 0.
- Reset asserted mid-LOCK or mid-ISSUE → IDLE on the following cycle, with the pending slot cleared.
- Button latency: a pulse in cycle t while IDLE → command pulse in t+1 → LOCK in t+2..t+1+L → IDLE in t+2+L.
- UART latency: `i_rx_done` in cycle t → pending valid in t+1 → command pulse in t+2, provided the state is IDLE and no button fires.
- Minimum spacing between two command pulses is `LOCKOUT_CYCLES`+2 cycles.
- At most one command output is high in any cycle.
- `o_cmd_err` and `o_cmd_drop` are registered: each pulses one cycle after the cause.
- `o_busy` is high in ISSUE and LOCK.
- `i_mode` or `i_setting` changing during ISSUE or LOCK does not cancel the latched command.

## Test plan
- Reset, then mode 0 with `i_btn_up` in cycle 5 → `o_sw_runstop` high only in cycle 6; `o_busy` high for cycles 6–10; a second up pulse in cycle 8 produces no output.
- Mode 0, `i_rx_data`=0x52 with `i_rx_done` in cycle 3 → `o_sw_start` in cycle 5. A 0x41 byte → `o_cmd_err` next cycle and no command pulse.
- Mode 0 with the state held in LOCK:
  - bytes 0x53 and then 0x43 arrive two cycles apart;
  - 0x53 is stored; 0x43 → `o_cmd_drop`;
  - `o_sw_stop` is issued on return to IDLE.
- Mode 1, `i_setting`=1, `i_btn_left` and a pending `u` (0x75) in the same IDLE cycle → `o_tm_left` first; `o_tm_up` is issued exactly `LOCKOUT_CYCLES`+2 cycles later.
- Mode 1, `i_setting`=0:
  - `i_btn_up` → no output and `o_busy` stays 0;
  - byte `d` (0x64) → `o_cmd_drop` and no `o_tm_down`.
- `reset` asserted during LOCK with a command pending → all outputs 0 and IDLE the next cycle; the pending command is never issued.

Source files
------------

// File: rtl/watch_cmd_scheduler.sv
// watch_cmd_scheduler
//   Merges debounced button pulses and UART command bytes into single-cycle
//   command pulses for the stopwatch and watch controllers. Commands are
//   routed by i_mode, gated by i_setting for watch commands, and every issued
//   pulse is followed by LOCKOUT_CYCLES idle cycles.
//
//   state  | meaning
//   IDLE   | waiting; arbitrates button vs pending UART command
//   ISSUE  | one command pulse decoded from the latched code
//   LOCK   | lockout gap, counter runs down to 0
//
// Ports
//   clk, reset                      clock, synchronous active-high reset
//   i_mode                          0 = stopwatch target, 1 = watch target
//   i_setting                       watch-setting switch (watch commands need 1)
//   i_btn_left/right/up/down        debounced one-cycle button pulses
//   i_rx_data, i_rx_done            UART byte and its one-cycle strobe
//   o_sw_runstop/clear/start/stop   stopwatch command pulses
//   o_tm_left/right/up/down         watch-setting command pulses
//   o_busy                          high in ISSUE and LOCK
//   o_cmd_drop                      a UART command was discarded
//   o_cmd_err                       an unrecognised UART byte was received
module watch_cmd_scheduler #(
  parameter int LOCKOUT_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_mode,
  input  logic       i_setting,
  input  logic       i_btn_left,
  input  logic       i_btn_right,
  input  logic       i_btn_up,
  input  logic       i_btn_down,
  input  logic [7:0] i_rx_data,
  input  logic       i_rx_done,
  output logic       o_sw_runstop,
  output logic       o_sw_clear,
  output logic       o_sw_start,
  output logic       o_sw_stop,
  output logic       o_tm_left,
  output logic       o_tm_right,
  output logic       o_tm_up,
  output logic       o_tm_down,
  output logic       o_busy,
  output logic       o_cmd_drop,
  output logic       o_cmd_err
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_LOCK} state_t;

  // Bit 2 of a command code is its class: 0 = stopwatch, 1 = watch.
  localparam logic [2:0] C_SW_RUNSTOP = 3'd0;
  localparam logic [2:0] C_SW_CLEAR   = 3'd1;
  localparam logic [2:0] C_SW_START   = 3'd2;
  localparam logic [2:0] C_SW_STOP    = 3'd3;
  localparam logic [2:0] C_TM_LEFT    = 3'd4;
  localparam logic [2:0] C_TM_RIGHT   = 3'd5;
  localparam logic [2:0] C_TM_UP      = 3'd6;
  localparam logic [2:0] C_TM_DOWN    = 3'd7;

  localparam logic [3:0] LOCK_LOAD = (LOCKOUT_CYCLES > 0) ? 4'(LOCKOUT_CYCLES - 1) : 4'd0;

  state_t     state_q, state_d;
  logic [2:0] code_q, code_d;
  logic [3:0] cnt_q, cnt_d;
  logic       pend_v_q, pend_v_d;
  logic [2:0] pend_code_q, pend_code_d;
  logic       drop_q, drop_d;
  logic       err_q, err_d;

  logic       rx_known;
  logic [2:0] rx_code;
  logic       btn_hit;
  logic [2:0] btn_code;
  logic       pend_ok;
  logic       consume;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      code_q      <= 3'd0;
      cnt_q       <= 4'd0;
      pend_v_q    <= 1'b0;
      pend_code_q <= 3'd0;
      drop_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      code_q      <= code_d;
      cnt_q       <= cnt_d;
      pend_v_q    <= pend_v_d;
      pend_code_q <= pend_code_d;
      drop_q      <= drop_d;
      err_q       <= err_d;
    end
  end

  always_comb begin
    rx_known = 1'b1;
    rx_code  = 3'd0;
    case (i_rx_data)
      8'h52:   rx_code = C_SW_START;
      8'h53:   rx_code = C_SW_STOP;
      8'h43:   rx_code = C_SW_CLEAR;
      8'h6C:   rx_code = C_TM_LEFT;
      8'h72:   rx_code = C_TM_RIGHT;
      8'h75:   rx_code = C_TM_UP;
      8'h64:   rx_code = C_TM_DOWN;
      default: rx_known = 1'b0;
    endcase
  end

  // Only applicable buttons produce a hit; the rest vanish without side effects.
  always_comb begin
    btn_hit  = 1'b0;
    btn_code = 3'd0;
    if (!i_mode) begin
      if (i_btn_up) begin
        btn_hit  = 1'b1;
        btn_code = C_SW_RUNSTOP;
      end else if (i_btn_down) begin
        btn_hit  = 1'b1;
        btn_code = C_SW_CLEAR;
      end
    end else if (i_setting) begin
      btn_hit = i_btn_up | i_btn_down | i_btn_left | i_btn_right;
      if (i_btn_up)         btn_code = C_TM_UP;
      else if (i_btn_down)  btn_code = C_TM_DOWN;
      else if (i_btn_left)  btn_code = C_TM_LEFT;
      else                  btn_code = C_TM_RIGHT;
    end
  end

  assign pend_ok = pend_code_q[2] ? (i_mode & i_setting) : ~i_mode;

  always_comb begin
    state_d     = state_q;
    code_d      = code_q;
    cnt_d       = cnt_q;
    pend_v_d    = pend_v_q;
    pend_code_d = pend_code_q;
    drop_d      = 1'b0;
    err_d       = 1'b0;
    consume     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (btn_hit) begin
          code_d  = btn_code;
          state_d = S_ISSUE;
        end else if (pend_v_q) begin
          consume = 1'b1;
          if (pend_ok) begin
            code_d  = pend_code_q;
            state_d = S_ISSUE;
          end else begin
            drop_d = 1'b1;
          end
        end
      end
      S_ISSUE: begin
        cnt_d   = LOCK_LOAD;
        state_d = (LOCKOUT_CYCLES == 0) ? S_IDLE : S_LOCK;
      end
      S_LOCK: begin
        if (cnt_q == 4'd0) state_d = S_IDLE;
        else               cnt_d   = cnt_q - 4'd1;
      end
      default: state_d = S_IDLE;
    endcase

    if (consume) pend_v_d = 1'b0;

    // A slot being emptied this cycle can accept the arriving byte.
    if (i_rx_done) begin
      if (!rx_known) begin
        err_d = 1'b1;
      end else if (pend_v_q && !consume) begin
        drop_d = 1'b1;
      end else begin
        pend_v_d    = 1'b1;
        pend_code_d = rx_code;
      end
    end
  end

  logic issue;
  assign issue = (state_q == S_ISSUE);

  assign o_sw_runstop = issue && (code_q == C_SW_RUNSTOP);
  assign o_sw_clear   = issue && (code_q == C_SW_CLEAR);
  assign o_sw_start   = issue && (code_q == C_SW_START);
  assign o_sw_stop    = issue && (code_q == C_SW_STOP);
  assign o_tm_left    = issue && (code_q == C_TM_LEFT);
  assign o_tm_right   = issue && (code_q == C_TM_RIGHT);
  assign o_tm_up      = issue && (code_q == C_TM_UP);
  assign o_tm_down    = issue && (code_q == C_TM_DOWN);
  assign o_busy       = (state_q != S_IDLE);
  assign o_cmd_drop   = drop_q;
  assign o_cmd_err    = err_q;

endmodule
